// File: rtl/ser2par_bc_align.sv
// Per-lane serial-to-parallel converter with comma byte alignment.
// Hunts for COMMA bit-by-bit, then locks to a byte grid and emits data bytes once synchronized.
module ser2par_bc_align #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       byte_strobe
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [3:0] SYNC_CNT  = 4'(SYNC_COUNT);

  logic [1:0] state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;
  logic       strobe_q, strobe_d;
  logic [7:0] nxt_s;
  logic       boundary_s;

  function automatic logic is_comma(input logic [7:0] b);
    return (b == COMMA);
  endfunction

  assign nxt_s      = {sr_q[6:0], data_in};
  assign boundary_s = (bit_cnt_q == 3'd7);

  // Next-state logic: alignment FSM, byte counters and output capture.
  always_comb begin
    state_d   = state_q;
    sr_d      = nxt_s;
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    active_d  = active_q;
    strobe_d  = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (is_comma(nxt_s)) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
          state_d   = ST_ALIGN;
        end else begin
          state_d   = ST_SEARCH;
        end
      end
      ST_ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary_s) begin
          strobe_d = 1'b1;
          if (is_comma(nxt_s)) begin
            bc_cnt_d = (bc_cnt_q < SYNC_CNT) ? (bc_cnt_q + 4'd1) : bc_cnt_q;
            if ((bc_cnt_q + 4'd1) == SYNC_CNT) begin
              state_d  = ST_ACTIVE;
              active_d = 1'b1;
            end else begin
              state_d  = ST_ALIGN;
            end
          end else begin
            // Hunting resumes on the following edge, not this one.
            state_d  = ST_SEARCH;
            bc_cnt_d = 4'd0;
          end
        end else begin
          strobe_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary_s) begin
          strobe_d = 1'b1;
          data_d   = nxt_s;
          valid_d  = !is_comma(nxt_s);
        end else begin
          strobe_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_SEARCH;
        bit_cnt_d = 3'd0;
        bc_cnt_d  = 4'd0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_SEARCH;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
      strobe_q  <= strobe_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign active      = active_q;
  assign byte_strobe = strobe_q;

endmodule

// File: tb/tb_ser2par_bc_align.sv
// Scoreboard bench for ser2par_bc_align: a stream-level reference model predicts every
// byte_strobe event and the activation edge; a monitor pops and compares as strobes appear.
module tb_ser2par_bc_align;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int         SYNC  = 4;

  logic       clk_8f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       byte_strobe;

  typedef struct {
    int         edge_n;
    logic [7:0] data;
    logic       valid;
    logic       act;
  } exp_t;

  exp_t exp_q[$];
  bit   stim_bits[$];
  int   exp_act_edge;
  int   edge_n;
  int   rise_edge;
  int   n_checks;
  int   n_err;

  ser2par_bc_align #(.COMMA(COMMA), .SYNC_COUNT(SYNC)) dut (
    .clk_8f      (clk_8f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .active      (active),
    .byte_strobe (byte_strobe)
  );

  initial begin
    clk_8f = 1'b0;
    forever #5 clk_8f = ~clk_8f;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_n);
    end
  endtask

  // Byte ending at bit index k of the stream; bits before the stream start read as 0.
  function automatic logic [7:0] win(input int k);
    logic [7:0] w;
    w = 8'h00;
    for (int b = 0; b < 8; b++) begin
      int idx;
      idx = k - 7 + b;
      w = {w[6:0], (idx >= 0) ? stim_bits[idx] : 1'b0};
    end
    return w;
  endfunction

  // Reference model: bit index k is sampled on edge k+1.
  task automatic build_model();
    int n, pos, i, j, cnt;
    bit found, broke;
    exp_t e;
    n = stim_bits.size();
    pos = 0;
    exp_act_edge = 0;
    while (pos < n) begin
      found = 0;
      for (i = pos; i < n; i++) begin
        if (win(i) == COMMA) begin
          found = 1;
          break;
        end
      end
      if (!found) break;
      cnt = 1;
      broke = 0;
      j = i + 8;
      while (j < n && cnt < SYNC) begin
        if (win(j) == COMMA) begin
          cnt++;
          if (cnt == SYNC) exp_act_edge = j + 1;
          e = '{edge_n: j + 1, data: 8'h00, valid: 1'b0, act: (cnt == SYNC)};
          exp_q.push_back(e);
        end else begin
          e = '{edge_n: j + 1, data: 8'h00, valid: 1'b0, act: 1'b0};
          exp_q.push_back(e);
          broke = 1;
          pos = j + 1;
        end
        j += 8;
        if (broke) break;
      end
      if (cnt == SYNC) begin
        for (int k = j; k < n; k += 8) begin
          e = '{edge_n: k + 1, data: win(k), valid: (win(k) != COMMA), act: 1'b1};
          exp_q.push_back(e);
        end
        break;
      end
      if (!broke) break;
    end
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) stim_bits.push_back(b[i]);
  endtask

  task automatic hold_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_8f);
      data_in = 1'($urandom);
    end
  endtask

  // Drive the staged stream from reset release, then reset asynchronously mid-cycle.
  task automatic run_session(input int want_rise);
    build_model();
    @(negedge clk_8f);
    reset   = 1'b1;
    data_in = stim_bits[0];
    for (int k = 1; k < stim_bits.size(); k++) begin
      @(negedge clk_8f);
      data_in = stim_bits[k];
    end
    @(posedge clk_8f);
    #2;
    reset = 1'b0;
    #1;
    check("async_clear", {data_out, valid_out, active, byte_strobe}, 32'h0);
    check("pending_events", exp_q.size(), 0);
    if (want_rise >= 0) check("rise_edge", rise_edge, want_rise);
    exp_q.delete();
    stim_bits.delete();
    exp_act_edge = 0;
    hold_reset();
  endtask

  // Monitor: per-edge reset/active checks and scoreboard pops on byte_strobe.
  initial begin
    exp_t e;
    edge_n = 0;
    rise_edge = 0;
    forever begin
      @(posedge clk_8f);
      #1;
      if (!reset) begin
        edge_n = 0;
        rise_edge = 0;
        check("reset_outputs", {data_out, valid_out, active, byte_strobe}, 32'h0);
      end else begin
        edge_n++;
        if (active && rise_edge == 0) rise_edge = edge_n;
        check("active_level", active, (exp_act_edge != 0 && edge_n >= exp_act_edge));
        if (byte_strobe) begin
          if (exp_q.size() == 0) begin
            check("strobe_unexpected", edge_n, 0);
          end else begin
            e = exp_q.pop_front();
            check("strobe_edge", edge_n, e.edge_n);
            check("data_out", data_out, e.data);
            check("valid_out", valid_out, e.valid);
            check("active_at_strobe", active, e.act);
          end
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_err = 0;
    exp_act_edge = 0;
    reset = 1'b0;
    data_in = 1'b0;
    hold_reset();

    // Aligned sync: commas from the first bit.
    for (int i = 0; i < 4; i++) add_byte(COMMA);
    add_byte(8'hFF);
    add_byte(8'h5A);
    run_session(32);

    // Misaligned sync: 3-bit prefix.
    stim_bits.push_back(1'b1);
    stim_bits.push_back(1'b0);
    stim_bits.push_back(1'b1);
    for (int i = 0; i < 4; i++) add_byte(COMMA);
    add_byte(8'h3C);
    run_session(35);

    // Broken sync then fresh commas.
    for (int i = 0; i < 3; i++) add_byte(COMMA);
    add_byte(8'h55);
    for (int i = 0; i < 4; i++) add_byte(COMMA);
    add_byte(8'h12);
    run_session(64);

    // Idle in ACTIVE followed by 64 random bytes.
    for (int i = 0; i < 4; i++) add_byte(COMMA);
    add_byte(COMMA);
    add_byte(8'h01);
    for (int i = 0; i < 64; i++) add_byte(8'($urandom));
    run_session(32);

    // Random prefixes of noise before sync, then random payload.
    for (int s = 0; s < 3; s++) begin
      int plen;
      plen = $urandom_range(0, 20);
      for (int i = 0; i < plen; i++) stim_bits.push_back(1'($urandom));
      for (int i = 0; i < 4; i++) add_byte(COMMA);
      for (int i = 0; i < 16; i++) add_byte(8'($urandom));
      run_session(-1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
